// File: rtl/rv32_pc_pkg.sv
// Shared next-PC select codes and alignment helpers for the RV32 fetch PC generator.
package rv32_pc_pkg;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_SEQ,
        NPC_RAS,
        NPC_REDIR,
        NPC_TRAP
    } npc_sel_e;

    // Low address bits that must be zero for a 32-bit aligned instruction fetch.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: push, pop and same-cycle replace, with saturating
// occupancy count. Pushing while full overwrites the oldest entry.
module ras_stack #(
    parameter int PC_WIDTH  = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [PC_WIDTH-1:0] push_addr,
    input  logic                pop,
    output logic [PC_WIDTH-1:0] top_data,
    output logic                empty,
    output logic                full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    r_top;
    logic [CNT_W-1:0]    r_count;

    logic             w_do_pop;
    logic             w_replace;
    logic             w_push_only;
    logic [PTR_W-1:0] w_top_inc;
    logic [PTR_W-1:0] w_top_dec;

    assign empty       = (r_count == '0);
    assign full        = (r_count == CNT_W'(RAS_DEPTH));
    assign top_data    = r_mem[r_top];

    // A pop on an empty stack is ignored, so push+pop there degrades to a plain push.
    assign w_do_pop    = pop & ~empty;
    assign w_replace   = push & w_do_pop;
    assign w_push_only = push & ~w_do_pop;
    assign w_top_inc   = r_top + PTR_W'(1);
    assign w_top_dec   = r_top - PTR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (w_push_only) begin
            r_top <= w_top_inc;
            if (!full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_do_pop && !w_replace) begin
            r_top   <= w_top_dec;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_replace) begin
            r_mem[r_top] <= push_addr;
        end else if (w_push_only) begin
            r_mem[w_top_inc] <= push_addr;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: picks the next PC from trap, EX redirect, RAS prediction
// or sequential increment, and holds on load-use stalls.
module pc_gen
    import rv32_pc_pkg::*;
#(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VEC = '0,
    parameter int                  PC_INC    = 4,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_write,
    input  logic                trap_valid,
    input  logic [PC_WIDTH-1:0] trap_vec,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                ras_push,
    input  logic [PC_WIDTH-1:0] ras_push_addr,
    input  logic                ras_pop,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                pc_misalign,
    output logic                ras_empty,
    output logic                ras_full
);

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_misalign;

    logic [PC_WIDTH-1:0] w_ras_top;
    logic                w_ras_ok;
    logic                w_push;
    logic                w_pop;
    npc_sel_e            w_sel;
    logic [PC_WIDTH-1:0] w_target;

    // Calls/returns seen on a path that is being flushed must not touch the RAS.
    assign w_ras_ok = pc_write & ~trap_valid & ~redirect_valid;
    assign w_push   = ras_push & w_ras_ok;
    assign w_pop    = ras_pop & w_ras_ok & ~ras_empty;
    assign w_target = trap_valid ? trap_vec : redirect_pc;

    always_comb begin
        w_sel = NPC_HOLD;
        if (trap_valid) begin
            w_sel = NPC_TRAP;
        end else if (redirect_valid) begin
            w_sel = NPC_REDIR;
        end else if (w_pop) begin
            w_sel = NPC_RAS;
        end else if (pc_write) begin
            w_sel = NPC_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_VEC;
            r_misalign <= 1'b0;
        end else begin
            case (w_sel)
                NPC_TRAP, NPC_REDIR: begin
                    r_pc       <= {w_target[PC_WIDTH-1:2], 2'b00};
                    r_misalign <= is_misaligned(w_target[1:0]);
                end
                NPC_RAS: begin
                    r_pc       <= w_ras_top;
                    r_misalign <= 1'b0;
                end
                NPC_SEQ: begin
                    r_pc       <= r_pc + PC_WIDTH'(PC_INC);
                    r_misalign <= 1'b0;
                end
                default: begin
                    r_pc       <= r_pc;
                    r_misalign <= r_misalign;
                end
            endcase
        end
    end

    ras_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_addr (ras_push_addr),
        .pop       (w_pop),
        .top_data  (w_ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign pc_out      = r_pc;
    assign pc_misalign = r_misalign;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a queue-based reference model predicts each cycle's
// outputs, a separate monitor compares them one cycle later.
module tb_pc_gen;

    localparam int          W     = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          INC   = 4;
    localparam int          DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          pc_write;
    logic          trap_valid;
    logic [W-1:0]  trap_vec;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          ras_push;
    logic [W-1:0]  ras_push_addr;
    logic          ras_pop;
    logic [W-1:0]  pc_out;
    logic          pc_misalign;
    logic          ras_empty;
    logic          ras_full;

    pc_gen #(
        .PC_WIDTH  (W),
        .RESET_VEC (RV),
        .PC_INC    (INC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ras_push       (ras_push),
        .ras_push_addr  (ras_push_addr),
        .ras_pop        (ras_pop),
        .pc_out         (pc_out),
        .pc_misalign    (pc_misalign),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic        mis;
        logic        emp;
        logic        full;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference state: the RAS is simply a list of addresses, newest at the back.
    logic [31:0] m_pc  = 32'h0;
    logic        m_mis = 1'b0;
    logic [31:0] m_ras[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic pw,
                        input logic tv, input logic [31:0] tvec,
                        input logic rv, input logic [31:0] rpc,
                        input logic pu, input logic [31:0] pa,
                        input logic po);
        exp_t        e;
        logic [31:0] tgt;
        logic        flush;
        @(negedge clk);
        rst_n          = rst;
        pc_write       = pw;
        trap_valid     = tv;
        trap_vec       = tvec;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ras_push       = pu;
        ras_push_addr  = pa;
        ras_pop        = po;

        flush = tv || rv;
        tgt   = tv ? tvec : rpc;
        if (!rst) begin
            m_pc  = RV;
            m_mis = 1'b0;
            m_ras.delete();
        end else if (flush) begin
            m_pc  = tgt & 32'hFFFF_FFFC;
            m_mis = (tgt % 4) != 0;
        end else if (pw) begin
            if (po && m_ras.size() > 0) begin
                m_pc = m_ras[m_ras.size()-1];
                if (pu) m_ras[m_ras.size()-1] = pa;
                else    void'(m_ras.pop_back());
            end else begin
                if (pu) begin
                    if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(pa);
                end
                m_pc = m_pc + INC;
            end
            m_mis = 1'b0;
        end

        e.pc   = m_pc;
        e.mis  = m_mis;
        e.emp  = (m_ras.size() == 0);
        e.full = (m_ras.size() == DEPTH);
        sb_q.push_back(e);
    endtask

    task automatic seq(input logic pw);
        step(1, pw, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] a);
        step(1, 1, 0, 0, 0, 0, 1, a, 0);
    endtask

    task automatic pop();
        step(1, 1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Monitor: every rising edge produces one observable PC state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc_out",      pc_out,             e.pc);
                check("pc_misalign", {31'b0, pc_misalign}, {31'b0, e.mis});
                check("ras_empty",   {31'b0, ras_empty},   {31'b0, e.emp});
                check("ras_full",    {31'b0, ras_full},    {31'b0, e.full});
            end
        end
    end

    initial begin
        rst_n = 1'b0; pc_write = 1'b0; trap_valid = 1'b0; trap_vec = '0;
        redirect_valid = 1'b0; redirect_pc = '0; ras_push = 1'b0;
        ras_push_addr = '0; ras_pop = 1'b0;

        // Reset, sequential run, one-cycle stall
        step(0, 1, 1, 32'h200, 1, 32'h300, 1, 32'h44, 1);
        seq(1); seq(1); seq(0); seq(1);

        // Flush beats stall, trap beats redirect
        step(1, 0, 0, 0, 1, 32'h100, 0, 0, 0);
        step(1, 0, 1, 32'h200, 1, 32'h300, 0, 0, 0);

        // Misaligned redirect, then sequential clears the flag; hold keeps it
        step(1, 1, 0, 0, 1, 32'h103, 0, 0, 0);
        seq(0);
        seq(1);
        step(1, 0, 1, 32'h202, 0, 0, 0, 0, 0);
        seq(0);

        // Overflowing RAS, drain it, then pop on empty
        push(32'h10); push(32'h20); push(32'h30); push(32'h40); push(32'h50);
        pop(); pop(); pop(); pop(); pop();

        // Push+pop replace, wrong-path push, reset mid-sequence
        push(32'h10); push(32'h20);
        step(1, 1, 0, 0, 0, 0, 1, 32'h99, 1);
        step(1, 1, 0, 0, 1, 32'h400, 1, 32'h77, 0);
        step(1, 0, 0, 0, 0, 0, 1, 32'h66, 0);
        pop(); pop();
        step(1, 1, 0, 0, 0, 0, 1, 32'h88, 1);
        push(32'h11);
        step(0, 1, 0, 0, 0, 0, 1, 32'h22, 0);
        pop();

        // PC wrap-around at the top of the address space
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        seq(1);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic        r_rst, r_pw, r_tv, r_rv, r_pu, r_po;
            logic [31:0] r_tvec, r_rpc, r_pa;
            r_rst  = ($urandom_range(0, 99) >= 2);
            r_pw   = ($urandom_range(0, 99) < 80);
            r_tv   = ($urandom_range(0, 99) < 5);
            r_rv   = ($urandom_range(0, 99) < 10);
            r_pu   = ($urandom_range(0, 99) < 30);
            r_po   = ($urandom_range(0, 99) < 30);
            r_tvec = $urandom();
            r_rpc  = $urandom();
            r_pa   = $urandom();
            step(r_rst, r_pw, r_tv, r_tvec, r_rv, r_rpc, r_pu, r_pa, r_po);
        end

        @(posedge clk);
        #3;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
